shift_wb_stage: RTL and testbench

Registered writeback stage directly downstream of the 32-bit barrel shifter in the MIPS integer datapath. It captures each shift result (YLO, C) with its destination register and shift type into a small FIFO. It generates C/N/Z status flags and presents results to the register-file write port over a valid/ready handshake. It also keeps a sticky error flag for illegal shift types and a saturating count of completed shift writebacks.

---
 rtl/shift_pkg.sv | 21 ++
 rtl/wb_fifo.sv | 68 ++++++
 rtl/shift_wb_stage.sv | 118 +++++++++++
 tb/tb_shift_wb_stage.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared shift-type encodings and status flag bit positions used by the
// barrel shifter and its writeback stage.
package shift_pkg;

    localparam logic [4:0] SRL = 5'h0C;
    localparam logic [4:0] SRA = 5'h0D;
    localparam logic [4:0] SLL = 5'h0E;

    localparam int C_IDX = 2;
    localparam int N_IDX = 1;
    localparam int Z_IDX = 0;

    localparam int TYPE_W = 5;
    localparam int DEST_W = 5;
    localparam int FLAG_W = 3;

    function automatic logic is_legal_type(input logic [TYPE_W-1:0] t);
        return (t == SRL) || (t == SRA) || (t == SLL);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Generic synchronous FIFO with registered occupancy; DEPTH must be a power
// of two so the pointers wrap without explicit compare logic.
module wb_fifo #(
    parameter int W     = 40,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
        mem_q <= mem_d;
    end

endmodule

// File: rtl/shift_wb_stage.sv
// Writeback stage behind the barrel shifter: tags each result with C/N/Z,
// queues it for the register-file write port and tracks errors and completions.
module shift_wb_stage
    import shift_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [TYPE_W-1:0]   s_type,
    input  logic [DW-1:0]       yl_in,
    input  logic                c_in,
    input  logic [DEST_W-1:0]   dest_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DW-1:0]       y_out,
    output logic [DEST_W-1:0]   dest_out,
    output logic [FLAG_W-1:0]   flags_out,
    output logic [FLAG_W-1:0]   status,
    output logic                err_sticky,
    input  logic                clr_err,
    output logic [CNT_W-1:0]    shift_cnt
);

    localparam int EW = DW + DEST_W + FLAG_W;
    localparam int AW = $clog2(DEPTH);

    logic              push, pop, legal, store, show_head;
    logic [EW-1:0]     wdata, rdata;
    logic              full, empty;
    logic [AW:0]       count;
    logic [FLAG_W-1:0] flags_new;
    logic [DW-1:0]     head_y;
    logic [DEST_W-1:0] head_dest;
    logic [FLAG_W-1:0] head_flags;

    logic [FLAG_W-1:0] status_q, status_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Handshakes depend only on registered occupancy, never on out_ready.
    assign in_ready  = !full && !reset;
    assign out_valid = (count != '0) && !reset;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign legal     = is_legal_type(s_type);
    assign store     = push && legal;

    always_comb begin
        flags_new        = '0;
        flags_new[C_IDX] = c_in;
        flags_new[N_IDX] = yl_in[DW-1];
        flags_new[Z_IDX] = (yl_in == '0);
    end

    assign wdata = {yl_in, dest_in, flags_new};
    assign {head_y, head_dest, head_flags} = rdata;

    assign show_head = !empty && !reset;
    assign y_out     = show_head ? head_y     : '0;
    assign dest_out  = show_head ? head_dest  : '0;
    assign flags_out = show_head ? head_flags : '0;

    wb_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (store),
        .wdata (wdata),
        .pop   (pop),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // A new illegal push outranks a simultaneous clear.
    always_comb begin
        status_d = status_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        if (pop) begin
            status_d = head_flags;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (clr_err) begin
            err_d = 1'b0;
        end
        if (push && !legal) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            status_q <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            status_q <= status_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign status     = status_q;
    assign err_sticky = err_q;
    assign shift_cnt  = cnt_q;

endmodule

// File: tb/tb_shift_wb_stage.sv
// Scoreboard bench for shift_wb_stage: a reference queue and counters track
// expected writebacks; a second instance with CNT_W=4 covers saturation.
module tb_shift_wb_stage;
    import shift_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1, in_valid = 1'b0, c_in = 1'b0, out_ready = 1'b0, clr_err = 1'b0;
    logic [4:0]  s_type = 5'h0, dest_in = 5'h0;
    logic [31:0] yl_in = 32'h0;
    logic        in_ready, out_valid, err_sticky;
    logic [31:0] y_out;
    logic [4:0]  dest_out;
    logic [2:0]  flags_out, status;
    logic [15:0] shift_cnt;
    logic        s_in_ready, s_out_valid, s_err_sticky;
    logic [31:0] s_y_out;
    logic [4:0]  s_dest_out;
    logic [2:0]  s_flags_out, s_status;
    logic [3:0]  s_shift_cnt;

    shift_wb_stage #(.DW(32), .DEPTH(2), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .s_type(s_type), .yl_in(yl_in), .c_in(c_in), .dest_in(dest_in),
        .out_valid(out_valid), .out_ready(out_ready), .y_out(y_out),
        .dest_out(dest_out), .flags_out(flags_out), .status(status),
        .err_sticky(err_sticky), .clr_err(clr_err), .shift_cnt(shift_cnt)
    );

    shift_wb_stage #(.DW(32), .DEPTH(2), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
        .s_type(s_type), .yl_in(yl_in), .c_in(c_in), .dest_in(dest_in),
        .out_valid(s_out_valid), .out_ready(out_ready), .y_out(s_y_out),
        .dest_out(s_dest_out), .flags_out(s_flags_out), .status(s_status),
        .err_sticky(s_err_sticky), .clr_err(clr_err), .shift_cnt(s_shift_cnt)
    );

    typedef struct {
        logic [31:0] y;
        logic [4:0]  d;
        logic [2:0]  f;
    } ent_t;

    ent_t       sbq[$];
    logic [2:0] m_status = 3'b000;
    logic       m_err = 1'b0;
    int         m_pops = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    function automatic logic [2:0] ref_flags(input logic [31:0] y, input logic c);
        return {c, y[31], (y == 32'd0)};
    endfunction

    function automatic logic [15:0] exp_cnt();
        return (m_pops > 65535) ? 16'hFFFF : 16'(m_pops);
    endfunction

    function automatic logic [3:0] exp_sat();
        return (m_pops > 15) ? 4'hF : 4'(m_pops);
    endfunction

    task automatic drive(input logic v, input logic [4:0] t, input logic [31:0] y,
                         input logic c, input logic [4:0] d);
        in_valid = v; s_type = t; yl_in = y; c_in = c; dest_in = d;
    endtask

    // Advance one clock, updating the reference model from the inputs seen at the edge.
    task automatic tick();
        logic can_push, can_pop;
        ent_t e;
        if (reset) begin
            sbq.delete();
            m_status = 3'b000;
            m_err    = 1'b0;
            m_pops   = 0;
        end else begin
            can_pop  = (sbq.size() != 0) && out_ready;
            can_push = in_valid && (sbq.size() < 2);
            if (can_pop) begin
                m_status = sbq[0].f;
                sbq.delete(0);
                m_pops++;
            end
            if (clr_err) m_err = 1'b0;
            if (can_push) begin
                if (s_type inside {SRL, SRA, SLL}) begin
                    e.y = yl_in; e.d = dest_in; e.f = ref_flags(yl_in, c_in);
                    sbq.push_back(e);
                end else begin
                    m_err = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; out_ready = 1'b0; clr_err = 1'b0;
        drive(1'b0, 5'h0, 32'h0, 1'b0, 5'h0);
        tick(); tick();
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %0b want 0", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
        n_cmp++; if (y_out !== 32'h0) begin n_bad++; $display("FAIL rst_y_out: got %0h want 0", y_out); end
        n_cmp++; if (flags_out !== 3'b000 || dest_out !== 5'h0) begin n_bad++; $display("FAIL rst_head: got flags %0b dest %0d want 0", flags_out, dest_out); end
        n_cmp++; if (status !== m_status) begin n_bad++; $display("FAIL rst_status: got %0b want %0b", status, m_status); end
        n_cmp++; if (err_sticky !== m_err) begin n_bad++; $display("FAIL rst_err: got %0b want %0b", err_sticky, m_err); end
        n_cmp++; if (shift_cnt !== exp_cnt()) begin n_bad++; $display("FAIL rst_cnt: got %0d want %0d", shift_cnt, exp_cnt()); end
        reset = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_in_ready: got %0b want 1", in_ready); end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        drive(1'b1, SRL, 32'h0000_0000, 1'b1, 5'd5);
        tick();
        drive(1'b0, 5'h0, 32'h0, 1'b0, 5'h0);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %0b want 1", out_valid); end
        n_cmp++; if (y_out !== sbq[0].y) begin n_bad++; $display("FAIL single_y: got %0h want %0h", y_out, sbq[0].y); end
        n_cmp++; if (dest_out !== sbq[0].d) begin n_bad++; $display("FAIL single_dest: got %0d want %0d", dest_out, sbq[0].d); end
        n_cmp++; if (flags_out !== sbq[0].f) begin n_bad++; $display("FAIL single_flags: got %0b want %0b", flags_out, sbq[0].f); end
        tick();
        n_cmp++; if (status !== m_status) begin n_bad++; $display("FAIL single_status: got %0b want %0b", status, m_status); end
        n_cmp++; if (shift_cnt !== exp_cnt()) begin n_bad++; $display("FAIL single_cnt: got %0d want %0d", shift_cnt, exp_cnt()); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_drained: got %0b want 0", out_valid); end
    endtask

    task automatic test_full();
        out_ready = 1'b0;
        drive(1'b1, SRA, 32'h8000_0001, 1'b0, 5'd7);
        tick();
        drive(1'b1, SLL, 32'h0000_0010, 1'b0, 5'd9);
        tick();
        drive(1'b0, 5'h0, 32'h0, 1'b0, 5'h0);
        n_cmp++; if (in_ready !== (sbq.size() < 2)) begin n_bad++; $display("FAIL full_in_ready: got %0b want %0b", in_ready, sbq.size() < 2); end
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL full_valid: got %0b want 1", out_valid); end
        n_cmp++; if (y_out !== sbq[0].y || flags_out !== sbq[0].f) begin n_bad++; $display("FAIL full_head0: got %0h/%0b want %0h/%0b", y_out, flags_out, sbq[0].y, sbq[0].f); end
        out_ready = 1'b1;
        tick();
        n_cmp++; if (in_ready !== (sbq.size() < 2)) begin n_bad++; $display("FAIL full_reopen: got %0b want %0b", in_ready, sbq.size() < 2); end
        n_cmp++; if (y_out !== sbq[0].y || dest_out !== sbq[0].d || flags_out !== sbq[0].f) begin n_bad++; $display("FAIL full_head1: got %0h/%0d/%0b want %0h/%0d/%0b", y_out, dest_out, flags_out, sbq[0].y, sbq[0].d, sbq[0].f); end
        n_cmp++; if (status !== m_status) begin n_bad++; $display("FAIL full_status1: got %0b want %0b", status, m_status); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL full_drained: got %0b want 0", out_valid); end
        n_cmp++; if (status !== m_status) begin n_bad++; $display("FAIL full_status2: got %0b want %0b", status, m_status); end
        n_cmp++; if (shift_cnt !== exp_cnt() || s_shift_cnt !== exp_sat()) begin n_bad++; $display("FAIL full_cnt: got %0d/%0d want %0d/%0d", shift_cnt, s_shift_cnt, exp_cnt(), exp_sat()); end
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        drive(1'b1, 5'h1F, 32'hDEAD_BEEF, 1'b1, 5'd3);
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL ill_in_ready: got %0b want 1", in_ready); end
        tick();
        drive(1'b0, 5'h0, 32'h0, 1'b0, 5'h0);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ill_valid: got %0b want 0", out_valid); end
        n_cmp++; if (err_sticky !== m_err) begin n_bad++; $display("FAIL ill_err_set: got %0b want %0b", err_sticky, m_err); end
        n_cmp++; if (shift_cnt !== exp_cnt()) begin n_bad++; $display("FAIL ill_cnt: got %0d want %0d", shift_cnt, exp_cnt()); end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        n_cmp++; if (err_sticky !== m_err) begin n_bad++; $display("FAIL ill_err_clr: got %0b want %0b", err_sticky, m_err); end
        clr_err = 1'b1;
        drive(1'b1, 5'h0F, 32'h0000_0001, 1'b0, 5'd4);
        tick();
        clr_err = 1'b0;
        drive(1'b0, 5'h0, 32'h0, 1'b0, 5'h0);
        n_cmp++; if (err_sticky !== m_err) begin n_bad++; $display("FAIL ill_set_wins: got %0b want %0b", err_sticky, m_err); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ill_not_stored: got %0b want 0", out_valid); end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        n_cmp++; if (err_sticky !== m_err) begin n_bad++; $display("FAIL ill_err_clr2: got %0b want %0b", err_sticky, m_err); end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  types [3];
        logic [31:0] y;
        types[0] = SRL; types[1] = SRA; types[2] = SLL;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            y = (i % 7 == 0) ? 32'h0 : $urandom;
            drive(1'b1, types[$urandom_range(0, 2)], y, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
            if (i > 0) begin
                n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_gap[%0d]: got v%0b r%0b want v1 r1", i, out_valid, in_ready); end
                n_cmp++; if (y_out !== sbq[0].y || dest_out !== sbq[0].d || flags_out !== sbq[0].f) begin n_bad++; $display("FAIL b2b_data[%0d]: got %0h/%0d/%0b want %0h/%0d/%0b", i, y_out, dest_out, flags_out, sbq[0].y, sbq[0].d, sbq[0].f); end
            end
            tick();
        end
        drive(1'b0, 5'h0, 32'h0, 1'b0, 5'h0);
        n_cmp++; if (y_out !== sbq[0].y || flags_out !== sbq[0].f) begin n_bad++; $display("FAIL b2b_last: got %0h/%0b want %0h/%0b", y_out, flags_out, sbq[0].y, sbq[0].f); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drained: got %0b want 0", out_valid); end
        n_cmp++; if (shift_cnt !== exp_cnt()) begin n_bad++; $display("FAIL b2b_cnt: got %0d want %0d", shift_cnt, exp_cnt()); end
        n_cmp++; if (s_shift_cnt !== exp_sat()) begin n_bad++; $display("FAIL b2b_sat: got %0d want %0d", s_shift_cnt, exp_sat()); end
        n_cmp++; if (status !== m_status) begin n_bad++; $display("FAIL b2b_status: got %0b want %0b", status, m_status); end
    endtask

    task automatic test_reset_flush();
        out_ready = 1'b0;
        drive(1'b1, SLL, 32'hAAAA_5555, 1'b1, 5'd11);
        tick();
        drive(1'b1, SRA, 32'h0000_1234, 1'b0, 5'd12);
        tick();
        drive(1'b0, 5'h0, 32'h0, 1'b0, 5'h0);
        n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin n_bad++; $display("FAIL flush_prefill: got r%0b v%0b want r0 v1", in_ready, out_valid); end
        reset = 1'b1;
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_during: got r%0b v%0b want r0 v0", in_ready, out_valid); end
        n_cmp++; if (y_out !== 32'h0 || flags_out !== 3'b000) begin n_bad++; $display("FAIL flush_head_zero: got %0h/%0b want 0/0", y_out, flags_out); end
        tick();
        reset = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_after: got v%0b r%0b want v0 r1", out_valid, in_ready); end
        n_cmp++; if (status !== m_status || err_sticky !== m_err) begin n_bad++; $display("FAIL flush_status: got %0b/%0b want %0b/%0b", status, err_sticky, m_status, m_err); end
        n_cmp++; if (shift_cnt !== exp_cnt() || s_shift_cnt !== exp_sat()) begin n_bad++; $display("FAIL flush_cnt: got %0d/%0d want %0d/%0d", shift_cnt, s_shift_cnt, exp_cnt(), exp_sat()); end
        tick();
        tick();
        n_cmp++; if (out_valid !== 1'b0 || y_out !== 32'h0) begin n_bad++; $display("FAIL flush_stale: got v%0b y %0h want v0 y0", out_valid, y_out); end
        drive(1'b1, SRL, 32'h0000_0077, 1'b0, 5'd20);
        tick();
        drive(1'b0, 5'h0, 32'h0, 1'b0, 5'h0);
        n_cmp++; if (out_valid !== 1'b1 || y_out !== sbq[0].y || dest_out !== sbq[0].d) begin n_bad++; $display("FAIL flush_new: got v%0b %0h/%0d want v1 %0h/%0d", out_valid, y_out, dest_out, sbq[0].y, sbq[0].d); end
        tick();
        n_cmp++; if (shift_cnt !== exp_cnt() || status !== m_status) begin n_bad++; $display("FAIL flush_new_pop: got %0d/%0b want %0d/%0b", shift_cnt, status, exp_cnt(), m_status); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_illegal();
        test_back_to_back();
        test_reset_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

endmodule
